uart_sync_fifo: RTL and testbench

UART_SYNC_FIFO -- requirements
Module: uart_sync_fifo

---
 rtl/uart_fifo_pkg.sv | 15 +
 rtl/fifo_mod_ptr.sv | 31 +++
 rtl/uart_sync_fifo.sv | 112 +++++++++++
 tb/tb_uart_sync_fifo.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared sizing helpers and read-mode constants for the UART synchronous FIFO.
package uart_fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    function automatic int addr_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mod_ptr.sv
// Modulo-DEPTH pointer with a wrap bit that toggles on every rollover.
module fifo_mod_ptr #(
    parameter int DEPTH = 50,
    parameter int AW    = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] addr_o,
    output logic          wrap_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_o <= '0;
            wrap_o <= 1'b0;
        end else if (clr_i) begin
            addr_o <= '0;
            wrap_o <= 1'b0;
        end else if (inc_i) begin
            if (addr_o == AW'(DEPTH - 1)) begin
                addr_o <= '0;
                wrap_o <= ~wrap_o;
            end else begin
                addr_o <= addr_o + AW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with arbitrary depth, level flags, sticky error flags and
// selectable standard / first-word-fall-through read.
module uart_sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 50,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = FWFT_OFF
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic                              wren_i,
    input  logic [DATA_WIDTH-1:0]             wdata_i,
    input  logic                              rden_i,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic                              full_o,
    output logic                              empty_o,
    output logic                              almost_full_o,
    output logic                              almost_empty_o,
    output logic [cnt_width(FIFO_DEPTH)-1:0]  count_o,
    output logic                              overflow_o,
    output logic                              underflow_o
);

    localparam int ADDR_WIDTH = addr_width(FIFO_DEPTH);
    localparam int CNT_WIDTH  = cnt_width(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] waddr, raddr;
    logic                  wwrap, rwrap;
    logic                  rd_acc, wr_acc;

    always_comb begin
        full_o         = (waddr == raddr) && (wwrap != rwrap);
        empty_o        = (waddr == raddr) && (wwrap == rwrap);
        almost_full_o  = int'(count_o) >= AF_LEVEL;
        almost_empty_o = int'(count_o) <= AE_LEVEL;
    end

    // A full FIFO may still take a write when the same cycle drains a word.
    always_comb begin
        rd_acc = !flush_i && rden_i && !empty_o;
        wr_acc = !flush_i && wren_i && (!full_o || rd_acc);
    end

    fifo_mod_ptr #(.DEPTH(FIFO_DEPTH), .AW(ADDR_WIDTH)) u_wptr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (flush_i),
        .inc_i  (wr_acc),
        .addr_o (waddr),
        .wrap_o (wwrap)
    );

    fifo_mod_ptr #(.DEPTH(FIFO_DEPTH), .AW(ADDR_WIDTH)) u_rptr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (flush_i),
        .inc_i  (rd_acc),
        .addr_o (raddr),
        .wrap_o (rwrap)
    );

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[waddr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (flush_i) begin
            count_o <= '0;
        end else if (wr_acc && !rd_acc) begin
            count_o <= count_o + CNT_WIDTH'(1);
        end else if (rd_acc && !wr_acc) begin
            count_o <= count_o - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (flush_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (wren_i && full_o && !rd_acc) overflow_o <= 1'b1;
            if (rden_i && empty_o)           underflow_o <= 1'b1;
        end
    end

    generate
        if (FWFT == FWFT_ON) begin : g_fwft
            assign rdata_o = empty_o ? '0 : mem[raddr];
        end else begin : g_std
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rdata_o <= '0;
                end else if (rd_acc) begin
                    rdata_o <= mem[raddr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Randomized and directed checks of uart_sync_fifo (standard and FWFT builds) against a queue model.
module tb_uart_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fl [2];
    logic       wr [2];
    logic       rd [2];
    logic [7:0] wd [2];
    logic [7:0] rdata_w [2];
    logic       full_w [2], empty_w [2], af_w [2], ae_w [2], ovf_w [2], unf_w [2];
    logic [5:0] cnt0;
    logic [2:0] cnt1;

    int errors = 0;
    int checks = 0;

    // Reference model state per DUT
    int unsigned mq [2][$];
    int unsigned erd [2];
    bit          movf [2];
    bit          munf [2];
    int          DEP [2] = '{50, 5};
    int          AFL [2] = '{48, 4};
    int          AEL [2] = '{2, 1};

    always #5 clk = ~clk;

    uart_sync_fifo dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[0]), .wren_i(wr[0]), .wdata_i(wd[0]),
        .rden_i(rd[0]), .rdata_o(rdata_w[0]), .full_o(full_w[0]), .empty_o(empty_w[0]),
        .almost_full_o(af_w[0]), .almost_empty_o(ae_w[0]), .count_o(cnt0),
        .overflow_o(ovf_w[0]), .underflow_o(unf_w[0])
    );

    uart_sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[1]), .wren_i(wr[1]), .wdata_i(wd[1]),
        .rden_i(rd[1]), .rdata_o(rdata_w[1]), .full_o(full_w[1]), .empty_o(empty_w[1]),
        .almost_full_o(af_w[1]), .almost_empty_o(ae_w[1]), .count_o(cnt1),
        .overflow_o(ovf_w[1]), .underflow_o(unf_w[1])
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_dut(input int d);
        int unsigned sz;
        int unsigned gc;
        sz = mq[d].size();
        gc = (d == 0) ? int'(cnt0) : int'(cnt1);
        chk($sformatf("d%0d.count", d), gc, sz);
        chk($sformatf("d%0d.empty", d), empty_w[d], (sz == 0));
        chk($sformatf("d%0d.full", d), full_w[d], (sz == DEP[d]));
        chk($sformatf("d%0d.afull", d), af_w[d], (int'(sz) >= AFL[d]));
        chk($sformatf("d%0d.aempty", d), ae_w[d], (int'(sz) <= AEL[d]));
        chk($sformatf("d%0d.overflow", d), ovf_w[d], movf[d]);
        chk($sformatf("d%0d.underflow", d), unf_w[d], munf[d]);
        if (d == 0)
            chk("d0.rdata", rdata_w[0], erd[0]);
        else if (sz != 0)
            chk("d1.rdata_head", rdata_w[1], mq[1][0]);
    endtask

    task automatic model_step(input int d);
        int unsigned sz;
        bit mfull, memp, ra, wa;
        sz    = mq[d].size();
        mfull = (sz == DEP[d]);
        memp  = (sz == 0);
        if (fl[d]) begin
            mq[d].delete();
            movf[d] = 0;
            munf[d] = 0;
        end else begin
            ra = rd[d] && !memp;
            wa = wr[d] && (!mfull || ra);
            if (wr[d] && mfull && !ra) movf[d] = 1;
            if (rd[d] && memp)         munf[d] = 1;
            if (ra) erd[d] = mq[d].pop_front();
            if (wa) mq[d].push_back(int'(wd[d]));
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            fl[i] = 0; wr[i] = 0; rd[i] = 0; wd[i] = '0;
        end
    endtask

    task automatic step(input int d, input bit f, input bit w, input logic [7:0] v, input bit r);
        idle_all();
        fl[d] = f; wr[d] = w; wd[d] = v; rd[d] = r;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            erd[i]  = 0;
            movf[i] = 0;
            munf[i] = 0;
        end
    endtask

    // Asynchronous reset pulse issued between clock edges
    task automatic do_reset();
        idle_all();
        rst = 1;
        #1;
        model_reset();
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        #1;
        rst = 0;
        check_dut(0);
        check_dut(1);
    endtask

    initial begin
        logic [7:0] v;
        idle_all();
        #1;
        model_reset();
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        #1;
        rst = 0;

        // Fill standard FIFO with 0x00..0x31
        for (int i = 0; i < 50; i++) step(0, 0, 1, 8'(i), 0);
        // Overflow while full
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'hFF, 0);
        // Drain in order
        for (int i = 0; i < 50; i++) step(0, 0, 0, 8'h00, 1);
        // Underflow on empty
        for (int i = 0; i < 2; i++) step(0, 0, 0, 8'h00, 1);
        step(0, 1, 0, 8'h00, 0);

        // Full with simultaneous read/write across wrap
        for (int i = 0; i < 50; i++) step(0, 0, 1, 8'($urandom), 0);
        for (int i = 0; i < 200; i++) step(0, 0, 1, 8'($urandom), 1);

        // Flush with a concurrent write at count 10
        step(0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 8'($urandom), 0);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 1, 8'h11, 0);
        step(0, 0, 1, 8'h22, 0);
        step(0, 1, 1, 8'h77, 1);

        // Random traffic on the standard FIFO
        for (int i = 0; i < 600; i++) begin
            v = 8'($urandom);
            step(0, ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), v,
                 ($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 60; i++) step(0, 0, 0, 8'h00, 1);

        // FWFT: single write into empty falls through next cycle
        step(1, 0, 1, 8'hA5, 0);
        chk("d1.fwft_a5", rdata_w[1], 8'hA5);
        chk("d1.fwft_nonempty", empty_w[1], 0);
        step(1, 0, 1, 8'h3C, 0);
        step(1, 0, 1, 8'h5A, 0);
        do_reset();
        step(1, 0, 1, 8'hC3, 0);
        step(1, 0, 1, 8'h96, 0);
        chk("d1.first_after_reset", rdata_w[1], 8'hC3);

        // Random traffic on the FWFT FIFO, including full/empty edges
        for (int i = 0; i < 600; i++) begin
            v = 8'($urandom);
            step(1, ($urandom_range(0, 50) == 0), ($urandom_range(0, 1) != 0), v,
                 ($urandom_range(0, 1) != 0));
        end

        // Reset during a standard-mode burst; first write afterwards read back first
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'($urandom), 0);
        do_reset();
        step(0, 0, 1, 8'h5E, 0);
        step(0, 0, 0, 8'h00, 1);
        chk("d0.first_after_reset", rdata_w[0], 8'h5E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
